// File: rtl/ula_nbits_seq.sv
// ula_nbits_seq: registered, handshaked WIDTH-bit ALU (add, sub, signed LE, EQ, optional MUL).
// Define ULA_MUL_EN to build the shift-add multiplier; otherwise op 100 is reported as illegal.
module ula_nbits_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             ovf_o,
    output logic             zero_o,
    output logic             igual_o,
    output logic             err_o
);
`ifdef ULA_MUL_EN
    typedef enum logic [1:0] {IDLE, EXEC, MULT, DONE} state_t;
    localparam int CW = $clog2(WIDTH);
    logic [2*WIDTH-1:0] p_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH:0]     madd;
`else
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
`endif
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q, res_d;
    logic [2:0]         op_q;
    logic [WIDTH:0]     sum;
    logic               sub, carry_d, ovf_d, err_d;
    logic               accept;

    assign accept = state_q == IDLE && start_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
`ifdef ULA_MUL_EN
            IDLE: state_d = start_i ? (op_i == 3'b100 ? MULT : EXEC) : IDLE;
            MULT: state_d = cnt_q == CW'(WIDTH-1) ? EXEC : MULT;
`else
            IDLE: state_d = start_i ? EXEC : IDLE;
`endif
            EXEC: state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

`ifdef ULA_MUL_EN
    assign busy_o = state_q == EXEC || state_q == MULT;
`else
    assign busy_o = state_q == EXEC;
`endif
    assign done_o = state_q == DONE;

    // SUB reuses the adder as a + ~b + 1; ovf compares sign(a) with the effective sign of b
    always_comb begin
        sub     = op_q == 3'b001;
        sum     = {1'b0, a_q} + {1'b0, sub ? ~b_q : b_q} + (WIDTH+1)'(sub);
        res_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        err_d   = 1'b0;
        case (op_q)
            3'b000, 3'b001: begin
                res_d   = sum[WIDTH-1:0];
                carry_d = sum[WIDTH];
                ovf_d   = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ sub)) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'b010: res_d = WIDTH'($signed(a_q) <= $signed(b_q));
            3'b011: res_d = WIDTH'(a_q == b_q);
`ifdef ULA_MUL_EN
            3'b100: begin
                res_d   = p_q[WIDTH-1:0];
                carry_d = |p_q[2*WIDTH-1:WIDTH];
                ovf_d   = |p_q[2*WIDTH-1:WIDTH];
            end
`endif
            default: err_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_o <= '0;
            carry_o  <= 1'b0;
            ovf_o    <= 1'b0;
            zero_o   <= 1'b0;
            igual_o  <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q  <= a_i;
                b_q  <= b_i;
                op_q <= op_i;
            end
            if (state_q == EXEC) begin
                result_o <= res_d;
                carry_o  <= carry_d;
                ovf_o    <= ovf_d;
                zero_o   <= res_d == '0;
                igual_o  <= a_q == b_q;
                err_o    <= err_d;
            end
        end
    end

`ifdef ULA_MUL_EN
    // Multiplier sits in the low half and shifts out LSB-first while partial sums enter the high half
    assign madd = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, p_q[0] ? a_q : '0};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            p_q   <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            p_q   <= {{WIDTH{1'b0}}, b_i};
            cnt_q <= '0;
        end else if (state_q == MULT) begin
            p_q   <= {madd, p_q[WIDTH-1:1]};
            cnt_q <= cnt_q + CW'(1);
        end
    end
`endif
endmodule
